// File: rtl/regfile_pkg.sv
// Shared sizing defaults and controller state encoding for the register-array
// access path (controller, array wrapper and bench).
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_SETUP,
    R_SAMPLE,
    RESP
  } ctrl_state_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Request/response channels plus the register-array pins of the access controller.
// slave = the controller, master = the requester together with the array it fronts.
interface regfile_access_ctrl_if #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
);

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr_w;
  logic [ADDR_W-1:0]   req_addr_a;
  logic [ADDR_W-1:0]   req_addr_b;
  logic [DATA_W-1:0]   req_data;

  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_W-1:0]   resp_data1;
  logic [DATA_W-1:0]   resp_data2;

  logic                reg_write;
  logic [NUM_REGS-1:0] write_address;
  logic [DATA_W-1:0]   write_data;
  logic [NUM_REGS-1:0] read_address1;
  logic [NUM_REGS-1:0] read_address2;
  logic [DATA_W-1:0]   read_data1;
  logic [DATA_W-1:0]   read_data2;

  modport slave (
    input  req_valid, req_write, req_addr_w, req_addr_a, req_addr_b, req_data,
    input  resp_ready, read_data1, read_data2,
    output req_ready, resp_valid, resp_data1, resp_data2,
    output reg_write, write_address, write_data, read_address1, read_address2
  );

  modport master (
    output req_valid, req_write, req_addr_w, req_addr_a, req_addr_b, req_data,
    output resp_ready, read_data1, read_data2,
    input  req_ready, resp_valid, resp_data1, resp_data2,
    input  reg_write, write_address, write_data, read_address1, read_address2
  );

endinterface

// File: rtl/onehot_decoder.sv
// Register index to one-hot select; indices at or beyond NUM_REGS give all zeros
// and a low valid flag.
module onehot_decoder #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot,
  output logic                valid
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign onehot[gi] = (32'(addr) == gi);
    end
  endgenerate

  assign valid = |onehot;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequencer that turns write / dual-read requests into registered, glitch-free
// select and strobe sequences on the register array and returns read data.
module regfile_access_ctrl #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W
) (
  input logic                  clk,
  input logic                  rst,
  regfile_access_ctrl_if.slave bus
);

  import regfile_pkg::*;

  ctrl_state_t         state_reg, state_next;
  logic                req_ready_reg, req_ready_next;
  logic                resp_valid_reg, resp_valid_next;
  logic [DATA_W-1:0]   resp_data1_reg, resp_data1_next;
  logic [DATA_W-1:0]   resp_data2_reg, resp_data2_next;
  logic                reg_write_reg, reg_write_next;
  logic [NUM_REGS-1:0] write_address_reg, write_address_next;
  logic [DATA_W-1:0]   write_data_reg, write_data_next;
  logic [NUM_REGS-1:0] read_address1_reg, read_address1_next;
  logic [NUM_REGS-1:0] read_address2_reg, read_address2_next;
  logic                a_valid_reg, a_valid_next;
  logic                b_valid_reg, b_valid_next;

  // Decode straight from the request so the selects can be registered on the
  // accepting edge; index 0 = write, 1 = read port 1, 2 = read port 2.
  logic [ADDR_W-1:0]   dec_addr   [3];
  logic [NUM_REGS-1:0] dec_onehot [3];
  logic [2:0]          dec_valid;

  assign dec_addr[0] = bus.req_addr_w;
  assign dec_addr[1] = bus.req_addr_a;
  assign dec_addr[2] = bus.req_addr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dec
      onehot_decoder #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
      ) u_dec (
        .addr   (dec_addr[gi]),
        .onehot (dec_onehot[gi]),
        .valid  (dec_valid[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next         = state_reg;
    req_ready_next     = req_ready_reg;
    resp_valid_next    = resp_valid_reg;
    resp_data1_next    = resp_data1_reg;
    resp_data2_next    = resp_data2_reg;
    reg_write_next     = reg_write_reg;
    write_address_next = write_address_reg;
    write_data_next    = write_data_reg;
    read_address1_next = read_address1_reg;
    read_address2_next = read_address2_reg;
    a_valid_next       = a_valid_reg;
    b_valid_next       = b_valid_reg;

    case (state_reg)
      IDLE: begin
        if (bus.req_valid && req_ready_reg) begin
          req_ready_next = 1'b0;
          if (bus.req_write) begin
            write_address_next = dec_valid[0] ? dec_onehot[0] : '0;
            write_data_next    = bus.req_data;
            state_next         = W_SETUP;
          end else begin
            read_address1_next = dec_valid[1] ? dec_onehot[1] : '0;
            read_address2_next = dec_valid[2] ? dec_onehot[2] : '0;
            a_valid_next       = dec_valid[1];
            b_valid_next       = dec_valid[2];
            state_next         = R_SETUP;
          end
        end
      end
      W_SETUP: begin
        reg_write_next = 1'b1;
        state_next     = W_STROBE;
      end
      W_STROBE: begin
        reg_write_next = 1'b0;
        state_next     = W_HOLD;
      end
      W_HOLD: begin
        write_address_next = '0;
        req_ready_next     = 1'b1;
        state_next         = IDLE;
      end
      R_SETUP: begin
        state_next = R_SAMPLE;
      end
      R_SAMPLE: begin
        // An unselected port leaves its bus floating, so never sample it.
        resp_data1_next    = a_valid_reg ? bus.read_data1 : '0;
        resp_data2_next    = b_valid_reg ? bus.read_data2 : '0;
        read_address1_next = '0;
        read_address2_next = '0;
        resp_valid_next    = 1'b1;
        state_next         = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
          state_next      = IDLE;
        end
      end
      default: begin
        req_ready_next     = 1'b1;
        resp_valid_next    = 1'b0;
        reg_write_next     = 1'b0;
        write_address_next = '0;
        read_address1_next = '0;
        read_address2_next = '0;
        state_next         = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      req_ready_reg     <= 1'b1;
      resp_valid_reg    <= 1'b0;
      resp_data1_reg    <= '0;
      resp_data2_reg    <= '0;
      reg_write_reg     <= 1'b0;
      write_address_reg <= '0;
      write_data_reg    <= '0;
      read_address1_reg <= '0;
      read_address2_reg <= '0;
      a_valid_reg       <= 1'b0;
      b_valid_reg       <= 1'b0;
    end else begin
      state_reg         <= state_next;
      req_ready_reg     <= req_ready_next;
      resp_valid_reg    <= resp_valid_next;
      resp_data1_reg    <= resp_data1_next;
      resp_data2_reg    <= resp_data2_next;
      reg_write_reg     <= reg_write_next;
      write_address_reg <= write_address_next;
      write_data_reg    <= write_data_next;
      read_address1_reg <= read_address1_next;
      read_address2_reg <= read_address2_next;
      a_valid_reg       <= a_valid_next;
      b_valid_reg       <= b_valid_next;
    end
  end

  assign bus.req_ready     = req_ready_reg;
  assign bus.resp_valid    = resp_valid_reg;
  assign bus.resp_data1    = resp_data1_reg;
  assign bus.resp_data2    = resp_data2_reg;
  assign bus.reg_write     = reg_write_reg;
  assign bus.write_address = write_address_reg;
  assign bus.write_data    = write_data_reg;
  assign bus.read_address1 = read_address1_reg;
  assign bus.read_address2 = read_address2_reg;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: a 32-register and a 20-register
// instance, each in front of a behavioural array model.
module tb_regfile_access_ctrl;

  // Value seen on an unselected read bus; stands in for a floating bus.
  localparam logic [31:0] FLOAT_BUS = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  regfile_access_ctrl_if #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) bus32 ();
  regfile_access_ctrl_if #(.NUM_REGS(20), .ADDR_W(5), .DATA_W(32)) bus20 ();

  regfile_access_ctrl #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  regfile_access_ctrl #(.NUM_REGS(20), .ADDR_W(5), .DATA_W(32)) u_dut20 (
    .clk (clk),
    .rst (rst),
    .bus (bus20)
  );

  logic [31:0] mem32 [32];
  logic [31:0] mem20 [20];
  logic [31:0] sb32  [32];
  bit          mem_init_done;

  function automatic int oh_idx(input logic [31:0] oh);
    int r = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = i;
    return r;
  endfunction

  assign bus32.read_data1 = (|bus32.read_address1) ? mem32[oh_idx(bus32.read_address1)] : FLOAT_BUS;
  assign bus32.read_data2 = (|bus32.read_address2) ? mem32[oh_idx(bus32.read_address2)] : FLOAT_BUS;
  assign bus20.read_data1 = (|bus20.read_address1) ? mem20[oh_idx(32'(bus20.read_address1))] : FLOAT_BUS;
  assign bus20.read_data2 = (|bus20.read_address2) ? mem20[oh_idx(32'(bus20.read_address2))] : FLOAT_BUS;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32; i++) mem32[i] <= 32'hA500_0000 + i;
      for (int i = 0; i < 20; i++) mem20[i] <= 32'h5A00_0000 + i;
      mem_init_done <= 1'b1;
    end else begin
      if (bus32.reg_write)
        for (int i = 0; i < 32; i++) if (bus32.write_address[i]) mem32[i] <= bus32.write_data;
      if (bus20.reg_write)
        for (int i = 0; i < 20; i++) if (bus20.write_address[i]) mem20[i] <= bus20.write_data;
    end
  end

  // Advance one cycle; read and write selects must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if ((|bus32.write_address) && ((|bus32.read_address1) || (|bus32.read_address2))) begin
      errors++;
      $display("FAIL select_overlap32: wa=%h ra1=%h ra2=%h required no overlap",
               bus32.write_address, bus32.read_address1, bus32.read_address2);
    end
    checks++;
    if ((|bus20.write_address) && ((|bus20.read_address1) || (|bus20.read_address2))) begin
      errors++;
      $display("FAIL select_overlap20: wa=%h ra1=%h ra2=%h required no overlap",
               bus20.write_address, bus20.read_address1, bus20.read_address2);
    end
  endtask

  // Returns one cycle after the handshake edge (first cycle of the sequence).
  task automatic send32(input bit wr, input logic [4:0] aw, input logic [4:0] aa,
                        input logic [4:0] ab, input logic [31:0] d);
    int waited = 0;
    while (bus32.req_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus32.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout32: req_ready=%b after %0d cycles, required 1", bus32.req_ready, waited);
    end
    bus32.req_valid  = 1'b1;
    bus32.req_write  = wr;
    bus32.req_addr_w = aw;
    bus32.req_addr_a = aa;
    bus32.req_addr_b = ab;
    bus32.req_data   = d;
    tick();
    bus32.req_valid  = 1'b0;
    $display("txn dut32 %s aw=%0d aa=%0d ab=%0d data=%h", wr ? "write" : "read ", aw, aa, ab, d);
  endtask

  task automatic send20(input bit wr, input logic [4:0] aw, input logic [4:0] aa,
                        input logic [4:0] ab, input logic [31:0] d);
    int waited = 0;
    while (bus20.req_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus20.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout20: req_ready=%b after %0d cycles, required 1", bus20.req_ready, waited);
    end
    bus20.req_valid  = 1'b1;
    bus20.req_write  = wr;
    bus20.req_addr_w = aw;
    bus20.req_addr_a = aa;
    bus20.req_addr_b = ab;
    bus20.req_data   = d;
    tick();
    bus20.req_valid  = 1'b0;
    $display("txn dut20 %s aw=%0d aa=%0d ab=%0d data=%h", wr ? "write" : "read ", aw, aa, ab, d);
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (bus32.req_ready !== 1'b1 || bus32.resp_valid !== 1'b0 || bus32.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b resp_valid=%b reg_write=%b required 1 0 0",
               bus32.req_ready, bus32.resp_valid, bus32.reg_write);
    end
    checks++;
    if (bus32.write_address !== 32'h0 || bus32.read_address1 !== 32'h0 || bus32.read_address2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_selects: wa=%h ra1=%h ra2=%h required all 0",
               bus32.write_address, bus32.read_address1, bus32.read_address2);
    end
    checks++;
    if (bus32.write_data !== 32'h0 || bus32.resp_data1 !== 32'h0 || bus32.resp_data2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: wd=%h d1=%h d2=%h required all 0",
               bus32.write_data, bus32.resp_data1, bus32.resp_data2);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus32.req_ready !== 1'b1 || bus20.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: ready32=%b ready20=%b required 1 1", bus32.req_ready, bus20.req_ready);
    end
  endtask

  task automatic test_write();
    send32(1'b1, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus32.reg_write !== 1'(c == 2)) begin
        errors++;
        $display("FAIL write_strobe c%0d: got %b required %b", c, bus32.reg_write, (c == 2));
      end
      checks++;
      if (bus32.write_address !== 32'h0000_0020) begin
        errors++;
        $display("FAIL write_select c%0d: got %h required 00000020", c, bus32.write_address);
      end
      checks++;
      if (bus32.write_data !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL write_data c%0d: got %h required deadbeef", c, bus32.write_data);
      end
      checks++;
      if (bus32.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_busy c%0d: req_ready %b required 0", c, bus32.req_ready);
      end
      tick();
    end
    checks++;
    if (bus32.req_ready !== 1'b1 || bus32.write_address !== 32'h0 || bus32.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL write_done: ready=%b wa=%h reg_write=%b required 1 0 0",
               bus32.req_ready, bus32.write_address, bus32.reg_write);
    end
    sb32[5] = 32'hDEAD_BEEF;
  endtask

  task automatic test_read_same();
    bus32.resp_ready = 1'b1;
    send32(1'b0, 5'd0, 5'd5, 5'd5, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (bus32.resp_valid !== 1'b0 || bus32.read_address1 !== 32'h20 || bus32.read_address2 !== 32'h20) begin
        errors++;
        $display("FAIL read_select c%0d: resp_valid=%b ra1=%h ra2=%h required 0 20 20",
                 c, bus32.resp_valid, bus32.read_address1, bus32.read_address2);
      end
      tick();
    end
    checks++;
    if (bus32.resp_valid !== 1'b1 || bus32.resp_data1 !== 32'hDEAD_BEEF || bus32.resp_data2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_same_resp: valid=%b d1=%h d2=%h required 1 deadbeef deadbeef",
               bus32.resp_valid, bus32.resp_data1, bus32.resp_data2);
    end
    checks++;
    if (bus32.read_address1 !== 32'h0 || bus32.read_address2 !== 32'h0) begin
      errors++;
      $display("FAIL read_select_clear: ra1=%h ra2=%h required 0 0", bus32.read_address1, bus32.read_address2);
    end
    tick();
    checks++;
    if (bus32.resp_valid !== 1'b0 || bus32.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_turnaround: resp_valid=%b ready=%b required 0 1", bus32.resp_valid, bus32.req_ready);
    end
  endtask

  task automatic test_resp_stall();
    bus32.resp_ready = 1'b0;
    send32(1'b0, 5'd0, 5'd31, 5'd0, 32'h0);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus32.resp_valid !== 1'b1 || bus32.resp_data1 !== 32'hA500_001F || bus32.resp_data2 !== 32'hA500_0000) begin
        errors++;
        $display("FAIL stall_resp k%0d: valid=%b d1=%h d2=%h required 1 a500001f a5000000",
                 k, bus32.resp_valid, bus32.resp_data1, bus32.resp_data2);
      end
      checks++;
      if ((bus32.read_address1 | bus32.read_address2 | bus32.write_address) !== 32'h0 ||
          bus32.reg_write !== 1'b0 || bus32.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_quiet k%0d: ra1=%h ra2=%h wa=%h reg_write=%b ready=%b required 0 0 0 0 0",
                 k, bus32.read_address1, bus32.read_address2, bus32.write_address, bus32.reg_write, bus32.req_ready);
      end
      tick();
    end
    bus32.resp_ready = 1'b1;
    tick();
    checks++;
    if (bus32.resp_valid !== 1'b0 || bus32.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: resp_valid=%b ready=%b required 0 1", bus32.resp_valid, bus32.req_ready);
    end
  endtask

  task automatic test_out_of_range();
    bus20.resp_ready = 1'b1;
    send20(1'b0, 5'd0, 5'd25, 5'd3, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (bus20.read_address1 !== 20'h0 || bus20.read_address2 !== 20'h00008) begin
        errors++;
        $display("FAIL oor_read_select c%0d: ra1=%h ra2=%h required 00000 00008",
                 c, bus20.read_address1, bus20.read_address2);
      end
      tick();
    end
    checks++;
    if (bus20.resp_valid !== 1'b1 || bus20.resp_data1 !== 32'h0 || bus20.resp_data2 !== 32'h5A00_0003) begin
      errors++;
      $display("FAIL oor_read_resp: valid=%b d1=%h d2=%h required 1 00000000 5a000003",
               bus20.resp_valid, bus20.resp_data1, bus20.resp_data2);
    end
    tick();
    send20(1'b1, 5'd25, 5'd0, 5'd0, 32'h1234_5678);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (bus20.reg_write !== 1'(c == 2) || bus20.write_address !== 20'h0) begin
        errors++;
        $display("FAIL oor_write c%0d: reg_write=%b wa=%h required %b 00000",
                 c, bus20.reg_write, bus20.write_address, (c == 2));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_write();
    send32(1'b1, 5'd9, 5'd0, 5'd0, 32'hCAFE_F00D);
    tick();
    checks++;
    if (bus32.reg_write !== 1'b1) begin
      errors++;
      $display("FAIL midrst_strobe_pre: reg_write=%b required 1", bus32.reg_write);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus32.reg_write !== 1'b0 || bus32.write_address !== 32'h0 || bus32.write_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async: reg_write=%b wa=%h wd=%h required 0 0 0",
               bus32.reg_write, bus32.write_address, bus32.write_data);
    end
    checks++;
    if (bus32.req_ready !== 1'b1 || bus32.read_address1 !== 32'h0 || bus32.read_address2 !== 32'h0) begin
      errors++;
      $display("FAIL midrst_state: ready=%b ra1=%h ra2=%h required 1 0 0",
               bus32.req_ready, bus32.read_address1, bus32.read_address2);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus32.req_ready !== 1'b1 || bus32.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: ready=%b reg_write=%b required 1 0", bus32.req_ready, bus32.reg_write);
    end
    bus32.resp_ready = 1'b1;
    send32(1'b0, 5'd0, 5'd9, 5'd9, 32'h0);
    tick();
    tick();
    checks++;
    if (bus32.resp_valid !== 1'b1 || bus32.resp_data1 !== 32'hA500_0009 || bus32.resp_data2 !== 32'hA500_0009) begin
      errors++;
      $display("FAIL midrst_old_value: valid=%b d1=%h d2=%h required 1 a5000009 a5000009",
               bus32.resp_valid, bus32.resp_data1, bus32.resp_data2);
    end
  endtask

  task automatic test_back_to_back();
    bus32.resp_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      bit          wr = 1'($urandom_range(0, 1));
      logic [4:0]  aw = 5'($urandom_range(0, 31));
      logic [4:0]  aa = 5'($urandom_range(0, 31));
      logic [4:0]  ab = 5'($urandom_range(0, 31));
      logic [31:0] d  = $urandom;
      int          w  = 0;
      if (wr) begin
        send32(1'b1, aw, 5'd0, 5'd0, d);
        sb32[aw] = d;
      end else begin
        send32(1'b0, 5'd0, aa, ab, 32'h0);
        while (bus32.resp_valid !== 1'b1 && w < 10) begin
          tick();
          w++;
        end
        checks++;
        if (bus32.resp_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_resp_timeout n%0d: resp_valid=%b required 1", n, bus32.resp_valid);
        end
        checks++;
        if (bus32.resp_data1 !== sb32[aa] || bus32.resp_data2 !== sb32[ab]) begin
          errors++;
          $display("FAIL b2b_read n%0d: d1=%h d2=%h required %h %h (aa=%0d ab=%0d)",
                   n, bus32.resp_data1, bus32.resp_data2, sb32[aa], sb32[ab], aa, ab);
        end
      end
    end
  endtask

  initial begin
    bus32.req_valid = 1'b0; bus32.req_write = 1'b0; bus32.req_data = '0;
    bus32.req_addr_w = '0; bus32.req_addr_a = '0; bus32.req_addr_b = '0;
    bus32.resp_ready = 1'b1;
    bus20.req_valid = 1'b0; bus20.req_write = 1'b0; bus20.req_data = '0;
    bus20.req_addr_w = '0; bus20.req_addr_a = '0; bus20.req_addr_b = '0;
    bus20.resp_ready = 1'b1;
    for (int i = 0; i < 32; i++) sb32[i] = 32'hA500_0000 + i;

    test_reset();
    test_write();
    test_read_same();
    test_resp_stall();
    test_out_of_range();
    test_reset_mid_write();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
